// File: rtl/cell_pattern_exerciser.sv
// Drives one combinational cell with binary or Gray input sweeps,
// compacts the sampled output into a MISR and counts output transitions.
module cell_pattern_exerciser #(
    parameter int N_IN   = 6,
    parameter int SETTLE = 2
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            START,
    input  logic            MODE,
    input  logic [7:0]      REPEAT,
    output logic [N_IN-1:0] STIM,
    input  logic            QN,
    output logic            BUSY,
    output logic            DONE,
    output logic [15:0]     SIG,
    output logic [15:0]     TOGGLES
);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        FINISH
    } state_t;

    localparam logic [3:0] SC_LAST = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

    state_t          state;
    logic [N_IN-1:0] cnt;
    logic [N_IN-1:0] cnt_next;
    logic [7:0]      sweep;
    logic [7:0]      rep;
    logic            mode_q;
    logic [3:0]      sc;
    logic            first;
    logic            prev;
    logic            last;
    logic            toggle;
    logic [15:0]     sig_next;

    function automatic logic [N_IN-1:0] pattern(input logic m,
                                               input logic [N_IN-1:0] c);
        return m ? (c ^ (c >> 1)) : c;
    endfunction

    always_comb begin
        cnt_next = cnt + N_IN'(1);
        last     = (&cnt) && (sweep == rep);
        toggle   = !first && (QN != prev);
        sig_next = {SIG[14:0], 1'b0}
                 ^ (SIG[15] ? 16'h1021 : 16'h0000)
                 ^ {15'b0, QN};
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            cnt     <= '0;
            sweep   <= '0;
            rep     <= '0;
            mode_q  <= 1'b0;
            sc      <= '0;
            first   <= 1'b0;
            prev    <= 1'b0;
            STIM    <= '0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            SIG     <= '0;
            TOGGLES <= '0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        cnt     <= '0;
                        sweep   <= '0;
                        rep     <= REPEAT;
                        mode_q  <= MODE;
                        sc      <= '0;
                        first   <= 1'b1;
                        prev    <= 1'b0;
                        SIG     <= '0;
                        TOGGLES <= '0;
                        STIM    <= '0;
                        BUSY    <= 1'b1;
                        state   <= (SETTLE == 0) ? SAMPLE : DRIVE;
                    end
                end
                DRIVE: begin
                    if (sc == SC_LAST) begin
                        sc    <= '0;
                        state <= SAMPLE;
                    end else begin
                        sc <= sc + 4'd1;
                    end
                end
                SAMPLE: begin
                    SIG   <= sig_next;
                    first <= 1'b0;
                    prev  <= QN;
                    if (toggle && (TOGGLES != 16'hFFFF))
                        TOGGLES <= TOGGLES + 16'd1;
                    if (last) begin
                        STIM  <= '0;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                        state <= FINISH;
                    end else begin
                        // the all-ones pattern wraps cnt and closes a sweep
                        cnt  <= cnt_next;
                        STIM <= pattern(mode_q, cnt_next);
                        if (&cnt)
                            sweep <= sweep + 8'd1;
                        state <= (SETTLE == 0) ? SAMPLE : DRIVE;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cell_pattern_exerciser.sv
// Self-checking bench for cell_pattern_exerciser: table-driven sweeps,
// scoreboard of run results, plus reset/abort/START-during-BUSY sequences.
module tb_cell_pattern_exerciser;

    localparam int N = 6;
    localparam int S = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mode;
    logic [7:0]  rep;
    logic [N-1:0] stim;
    logic        qn;
    logic        busy;
    logic        done;
    logic [15:0] sig;
    logic [15:0] tog;
    int          qn_sel;

    logic        start2;
    logic [0:0]  stim2;
    logic        busy2;
    logic        done2;
    logic [15:0] sig2;
    logic [15:0] tog2;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] sig;
        logic [15:0] tog;
        int          len;
    } exp_t;

    typedef struct {
        logic       mode;
        logic [7:0] rep;
        int         sel;
        int         tog;
        int         len;
        string      name;
    } vec_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    assign qn = (qn_sel == 0) ? 1'b0 : (qn_sel == 1) ? 1'b1 : stim[0];

    cell_pattern_exerciser #(.N_IN(N), .SETTLE(S)) dut (
        .CLK(clk), .RST(rst), .START(start), .MODE(mode), .REPEAT(rep),
        .STIM(stim), .QN(qn), .BUSY(busy), .DONE(done),
        .SIG(sig), .TOGGLES(tog)
    );

    cell_pattern_exerciser #(.N_IN(1), .SETTLE(0)) dut2 (
        .CLK(clk), .RST(rst), .START(start2), .MODE(1'b0), .REPEAT(8'd0),
        .STIM(stim2), .QN(1'b1), .BUSY(busy2), .DONE(done2),
        .SIG(sig2), .TOGGLES(tog2)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [N-1:0] pat(input logic m, input int idx);
        logic [N-1:0] c;
        c = N'(idx % (1 << N));
        return m ? (c ^ (c >> 1)) : c;
    endfunction

    function automatic exp_t model(input logic m, input logic [7:0] r,
                                   input int sel);
        exp_t e;
        logic [N-1:0] p;
        logic q, pv;
        e.sig = 16'h0;
        e.tog = 16'h0;
        pv = 1'b0;
        for (int i = 0; i < (int'(r) + 1) * (1 << N); i++) begin
            p = pat(m, i);
            q = (sel == 0) ? 1'b0 : (sel == 1) ? 1'b1 : p[0];
            if (i != 0 && q != pv && e.tog != 16'hFFFF)
                e.tog = e.tog + 16'd1;
            pv = q;
            e.sig = {e.sig[14:0], 1'b0} ^ (e.sig[15] ? 16'h1021 : 16'h0)
                  ^ {15'b0, q};
        end
        e.len = (int'(r) + 1) * (1 << N) * (S + 1);
        return e;
    endfunction

    task automatic run(input logic m, input logic [7:0] r, input int sel,
                       input int exp_tog, input int exp_len,
                       input int pulse_at, input int abort_at,
                       input string name);
        exp_t e;
        exp_t got;
        int k;
        int bad;
        e = model(m, r, sel);
        qn_sel = sel;
        @(negedge clk);
        start = 1'b1;
        mode  = m;
        rep   = r;
        @(posedge clk);
        #1;
        start = 1'b0;
        mode  = ~m;
        rep   = ~r;
        if (abort_at < 0) sb.push_back(e);
        k = 0;
        bad = 0;
        while (k < 3000) begin
            @(negedge clk);
            start = (k == pulse_at);
            if (!busy) break;
            if (stim !== pat(m, k / (S + 1))) bad++;
            if (done !== 1'b0) bad++;
            if (k == abort_at) begin
                #2 rst = 1'b1;
                #1;
                chk({name, "_abort_busy"}, 32'(busy), 32'h0);
                chk({name, "_abort_stim"}, 32'(stim), 32'h0);
                @(negedge clk);
                rst = 1'b0;
                break;
            end
            k++;
        end
        start = 1'b0;
        chk({name, "_stim_walk"}, 32'(bad), 32'h0);
        if (abort_at >= 0) begin
            bad = 0;
            repeat (6) begin
                @(negedge clk);
                if (done !== 1'b0 || busy !== 1'b0) bad++;
            end
            chk({name, "_no_done"}, 32'(bad), 32'h0);
        end else begin
            chk({name, "_busy_len"}, 32'(k), 32'(exp_len));
            chk({name, "_done"}, 32'(done), 32'h1);
            if (sb.size() == 0) begin
                chk({name, "_sb_empty"}, 32'h0, 32'h1);
            end else begin
                got = sb.pop_front();
                chk({name, "_sig"}, 32'(sig), 32'(got.sig));
                chk({name, "_tog"}, 32'(tog), 32'(exp_tog));
                chk({name, "_tog_model"}, 32'(tog), 32'(got.tog));
                chk({name, "_len_model"}, 32'(k), 32'(got.len));
            end
            @(negedge clk);
            chk({name, "_done_pulse"}, 32'(done), 32'h0);
        end
    endtask

    vec_t vt[5];
    int k2;

    initial begin
        vt[0] = '{1'b0, 8'd0, 2, 63, 192, "bin"};
        vt[1] = '{1'b1, 8'd0, 2, 32, 192, "gray"};
        vt[2] = '{1'b0, 8'd1, 2, 127, 384, "bin_rep1"};
        vt[3] = '{1'b0, 8'd0, 0, 0, 192, "qn0"};
        vt[4] = '{1'b1, 8'd0, 1, 0, 192, "qn1_gray"};

        rst = 1'b1;
        start = 1'b1;
        start2 = 1'b1;
        mode = 1'b0;
        rep = 8'd0;
        qn_sel = 2;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_busy2", 32'(busy2), 32'h0);
        chk("rst_stim", 32'(stim), 32'h0);
        start = 1'b0;
        start2 = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", 32'(busy), 32'h0);
        chk("post_rst_sig", 32'(sig), 32'h0);

        for (int i = 0; i < 5; i++)
            run(vt[i].mode, vt[i].rep, vt[i].sel, vt[i].tog, vt[i].len,
                -1, -1, vt[i].name);

        run(1'b0, 8'd0, 2, 63, 192, 50, -1, "start_in_busy");

        @(negedge clk);
        chk("sig_hold", 32'(sig), 32'(model(1'b0, 8'd0, 2).sig));
        #2 rst = 1'b1;
        #1;
        chk("midrst_sig", 32'(sig), 32'h0);
        chk("midrst_tog", 32'(tog), 32'h0);
        chk("midrst_done", 32'(done), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        run(1'b1, 8'd0, 2, 32, 192, -1, 100, "abort");
        run(1'b1, 8'd0, 2, 32, 192, -1, -1, "after_abort");

        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
        k2 = 0;
        while (k2 < 20) begin
            @(negedge clk);
            if (!busy2) break;
            k2++;
        end
        chk("n1_len", 32'(k2), 32'h2);
        chk("n1_done", 32'(done2), 32'h1);
        chk("n1_sig", 32'(sig2), 32'h3);
        chk("n1_tog", 32'(tog2), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
